// File: rtl/bench_seq_pkg.sv
// Shared types and constants for the sequential benchmark / signature family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   mode_e       - state update rule selected at run time
//   fsm_e        - capture-window controller states
//   DEFAULT_POLY - default Galois feedback mask, truncated to STATE_W by users
//   cnt_width()  - width of a counter that must hold 0..window without wrapping
package bench_seq_pkg;

  // Update rule applied to the state register every cycle it is not frozen.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_XOR  = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_ROTX = 2'd3
  } mode_e;

  // Capture-window controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  // Wide enough for any practical STATE_W; callers cast it to their width.
  localparam int unsigned     POLY_MAX_W   = 64;
  localparam logic [POLY_MAX_W-1:0] DEFAULT_POLY = 64'h5;

  // The update counter reaches exactly `window` on the last update of a
  // window, so it needs room for that value as well as zero.
  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/bench_seq_next.sv
// Next-state function of the sequential benchmark: hold, XOR, Galois LFSR, rotate-XOR.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output is valid whenever inputs are.
//
// Ports:
//   state [STATE_W] - current state register value
//   in    [IN_W]    - data folded in, zero-extended to STATE_W
//   mode  [2]       - update rule (mode_e encoding)
//   next  [STATE_W] - state value for the next edge
module bench_seq_next
  import bench_seq_pkg::*;
#(
  parameter int                 STATE_W = 21,
  parameter int                 IN_W    = 3,
  parameter logic [STATE_W-1:0] POLY    = STATE_W'(DEFAULT_POLY)
) (
  input  logic [STATE_W-1:0] state,
  input  logic [IN_W-1:0]    in,
  input  logic [1:0]         mode,
  output logic [STATE_W-1:0] next
);

  logic [STATE_W-1:0] x;
  logic [STATE_W-1:0] shl;
  logic [STATE_W-1:0] rot;
  logic [STATE_W-1:0] fb;

  // The MSB leaves the register on a left shift; in LFSR mode it is what
  // selects the feedback mask, in ROTX mode it wraps back into bit 0.
  assign x   = STATE_W'(in);
  assign shl = {state[STATE_W-2:0], 1'b0};
  assign rot = {state[STATE_W-2:0], state[STATE_W-1]};
  assign fb  = state[STATE_W-1] ? POLY : '0;

  always_comb begin
    next = state;
    case (mode_e'(mode))
      MODE_HOLD: next = state;
      MODE_XOR:  next = state ^ x;
      MODE_LFSR: next = shl ^ fb ^ x;
      MODE_ROTX: next = rot ^ x;
      default:   next = state;
    endcase
  end

endmodule

// File: rtl/bench_seq_misr.sv
// Configurable sequential benchmark with a start/ack capture window compacting into a signature.
// Latency: out follows state one edge after in/mode; signature valid WINDOW+1 edges after start.
// Backpressure: start only honoured in IDLE; DONE holds (state frozen) until ack.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   in         - [IN_W] data folded into the state
//   mode       - [2] update rule: 0 HOLD, 1 XOR, 2 LFSR, 3 ROTX
//   start      - open a capture window (IDLE only)
//   ack        - release the signature (DONE only)
//   out        - [OUT_W] low bits of the state register
//   busy       - high while a window is running
//   sig_valid  - high while the signature waits for ack
//   signature  - [STATE_W] state value at the end of the last window
//   out_parity - (BENCH_SEQ_PARITY_EN) XOR-reduce of the state register
//   sig_parity - (BENCH_SEQ_PARITY_EN) parity captured with the signature
//
// Optional build macro: BENCH_SEQ_PARITY_EN adds the two parity outputs.
module bench_seq_misr
  import bench_seq_pkg::*;
#(
  parameter int                 STATE_W = 21,
  parameter int                 IN_W    = 3,
  parameter int                 OUT_W   = 6,
  parameter int                 WINDOW  = 8,
  parameter logic [STATE_W-1:0] SEED    = '0,
  parameter logic [STATE_W-1:0] POLY    = STATE_W'(DEFAULT_POLY)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_W-1:0]    in,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic               ack,
  output logic [OUT_W-1:0]   out,
  output logic               busy,
  output logic               sig_valid,
`ifdef BENCH_SEQ_PARITY_EN
  output logic [STATE_W-1:0] signature,
  output logic               out_parity,
  output logic               sig_parity
`else
  output logic [STATE_W-1:0] signature
`endif
);

  // ------------------------------------------------------------------
  // Parameter sanity: refuse to elaborate a configuration that would
  // slice outside the state register or never close a window.
  // ------------------------------------------------------------------
  if (STATE_W < 2) begin : g_bad_state_w
    $error("bench_seq_misr: STATE_W must be >= 2");
  end
  if (IN_W < 1 || IN_W > STATE_W) begin : g_bad_in_w
    $error("bench_seq_misr: IN_W must be in 1..STATE_W");
  end
  if (OUT_W < 1 || OUT_W > STATE_W) begin : g_bad_out_w
    $error("bench_seq_misr: OUT_W must be in 1..STATE_W");
  end
  if (WINDOW < 1) begin : g_bad_window
    $error("bench_seq_misr: WINDOW must be >= 1");
  end

  localparam int               CNT_W    = cnt_width(WINDOW);
  // Counter value seen while the WINDOW-th update is being applied.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  fsm_e               st_q,    st_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [STATE_W-1:0] sig_q,   sig_d;
  logic [STATE_W-1:0] next_w;

  // ------------------------------------------------------------------
  // Update rule
  // ------------------------------------------------------------------
  bench_seq_next #(
    .STATE_W (STATE_W),
    .IN_W    (IN_W),
    .POLY    (POLY)
  ) u_next (
    .state (state_q),
    .in    (in),
    .mode  (mode),
    .next  (next_w)
  );

  // ------------------------------------------------------------------
  // Controller: next-state and datapath select
  // ------------------------------------------------------------------
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;

    case (st_q)
      ST_IDLE: begin
        if (start) begin
          // A window always begins from a known seed so signatures are
          // independent of whatever the free-running state held.
          state_d = SEED;
          cnt_d   = '0;
          st_d    = ST_RUN;
        end else begin
          // Free-running outside a window keeps the legacy benchmark
          // behaviour of a state machine clocked every cycle.
          state_d = next_w;
        end
      end

      ST_RUN: begin
        state_d = next_w;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Capture the value being written, not the pre-update state.
          sig_d = next_w;
          st_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        // State frozen so the observed out matches the signature.
        // ack wins over start: a simultaneous start is dropped.
        if (ack) begin
          st_d = ST_IDLE;
        end
      end

      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign out       = state_q[OUT_W-1:0];
  assign busy      = (st_q == ST_RUN);
  assign sig_valid = (st_q == ST_DONE);
  assign signature = sig_q;

`ifdef BENCH_SEQ_PARITY_EN
  logic sig_parity_q;

  assign out_parity = ^state_q;
  assign sig_parity = sig_parity_q;

  // Parity of the captured word, taken on the same edge as the signature.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_parity_q <= 1'b0;
    end else if (st_q == ST_RUN && cnt_q == CNT_LAST) begin
      sig_parity_q <= ^next_w;
    end
  end
`endif

endmodule

// File: tb/tb_bench_seq_misr.sv
// Directed bench for bench_seq_misr with three parameterisations sharing one stimulus.
// a: defaults; b: SEED=1; c: WINDOW=1, SEED=21'h100000.
module tb_bench_seq_misr;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] in    = '0;
  logic [1:0] mode  = '0;
  logic       start = 1'b0;
  logic       ack   = 1'b0;

  logic [5:0]  out_a, out_b, out_c;
  logic        busy_a, busy_b, busy_c;
  logic        sv_a, sv_b, sv_c;
  logic [20:0] sig_a, sig_b, sig_c;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  always #5 clk = ~clk;

  bench_seq_misr dut_a (
    .clk(clk), .reset(reset), .in(in), .mode(mode), .start(start), .ack(ack),
    .out(out_a), .busy(busy_a), .sig_valid(sv_a), .signature(sig_a)
  );

  bench_seq_misr #(.SEED(21'h1)) dut_b (
    .clk(clk), .reset(reset), .in(in), .mode(mode), .start(start), .ack(ack),
    .out(out_b), .busy(busy_b), .sig_valid(sv_b), .signature(sig_b)
  );

  bench_seq_misr #(.WINDOW(1), .SEED(21'h100000)) dut_c (
    .clk(clk), .reset(reset), .in(in), .mode(mode), .start(start), .ack(ack),
    .out(out_c), .busy(busy_c), .sig_valid(sv_c), .signature(sig_c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it; drive and sample happen here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the start edge: counts RUN edges until busy drops.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy_a && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_all_done(input string tag);
    int k;
    k = 0;
    while (!(sv_a && sv_b && sv_c) && k < 40) begin
      tick();
      k++;
    end
    chk(tag, {29'd0, sv_a, sv_b, sv_c}, 32'h7);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    // 1. Reset and free-run (XOR with in=101).
    in    = 3'b101;
    mode  = 2'd1;
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_out",  out_a,  0);
    chk("rst_busy", busy_a, 0);
    chk("rst_sv",   sv_a,   0);
    chk("rst_sig",  sig_a,  0);
    chk("rst_sig_c", sig_c, 0);
    reset = 1'b1;
    tick();
    chk("freerun_e1", out_a, 6'b000101);
    tick();
    chk("freerun_e2", out_a, 6'b000000);
    chk("freerun_busy", busy_a, 0);

    // 2. XOR window, in=011 constant: even number of folds cancels.
    mode = 2'd1;
    in   = 3'b011;
    pulse_start();
    chk("xor_busy_now", busy_a, 1);
    count_busy(n);
    chk("xor_busy_len", n, 8);
    chk("xor_sv", sv_a, 1);
    chk("xor_sig_a", sig_a, 21'h0);
    wait_all_done("xor_all_done");
    chk("xor_sig_b", sig_b, 21'h1);
    chk("xor_sig_c", sig_c, 21'h100003);
    // DONE must freeze state regardless of in/mode.
    in = 3'b111;
    repeat (2) tick();
    chk("done_frozen_b", out_b, 6'h01);
    chk("done_sv_hold", sv_a, 1);
    pulse_ack();
    chk("ack_sv_low", sv_a, 0);
    chk("ack_sig_kept", sig_b, 21'h1);

    // 3. LFSR: pure shift for b, feedback for c.
    mode = 2'd2;
    in   = 3'b000;
    pulse_start();
    wait_all_done("lfsr_all_done");
    chk("lfsr_sig_a", sig_a, 21'h0);
    chk("lfsr_sig_b", sig_b, 21'h000100);
    chk("lfsr_sig_c", sig_c, 21'h000005);
    pulse_ack();

    // 4. ROTX: MSB wraps into bit 0 for c.
    mode = 2'd3;
    in   = 3'b000;
    pulse_start();
    wait_all_done("rotx_all_done");
    chk("rotx_sig_c", sig_c, 21'h000001);
    chk("rotx_sig_b", sig_b, 21'h000100);
    pulse_ack();

    // 5. Handshake: start and ack mid-RUN ignored; ack+start in DONE -> IDLE.
    //    ROTX with in=1 from 0: 1,3,7,..,0xFF after 8 updates.
    mode = 2'd3;
    in   = 3'b001;
    pulse_start();
    n = 0;
    while (busy_a && n < 40) begin
      start = (n == 3 || n == 4);
      ack   = (n == 5);
      tick();
      n++;
    end
    start = 1'b0;
    ack   = 1'b0;
    chk("hs_busy_len", n, 8);
    chk("hs_sig", sig_a, 21'h0000ff);
    chk("hs_out_done", out_a, 6'h3f);
    repeat (3) tick();
    chk("hs_sv_holds", sv_a, 1);
    start = 1'b1;
    ack   = 1'b1;
    tick();
    start = 1'b0;
    ack   = 1'b0;
    chk("hs_ackstart_sv", sv_a, 0);
    chk("hs_ackstart_busy", busy_a, 0);
    chk("hs_sig_retained", sig_a, 21'h0000ff);
    tick();
    chk("hs_no_restart", busy_a, 0);

    // 6. Reset after 3 updates of a window, then a full window.
    mode = 2'd3;
    in   = 3'b001;
    pulse_start();
    repeat (3) tick();
    chk("mid_run_out", out_a, 6'h07);
    reset = 1'b0;
    #1;
    chk("abort_out",  out_a,  0);
    chk("abort_busy", busy_a, 0);
    chk("abort_sv",   sv_a,   0);
    chk("abort_sig",  sig_a,  0);
    tick();
    reset = 1'b1;
    tick();
    pulse_start();
    count_busy(n);
    chk("post_rst_busy_len", n, 8);
    chk("post_rst_sig", sig_a, 21'h0000ff);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bench_seq_misr.md
Name: bench_seq_misr

Overview:
Parametrised successor to the generic benchmark sequential circuit: a STATE_W-bit state register with a run-time selectable update rule (hold, XOR-accumulate, Galois LFSR, rotate-XOR). A start/ack-controlled capture window compacts input activity into a signature register. It serves as a configurable golden/trojan-free sequential benchmark and signature generator in the hardware-trojan evaluation flow.

Parameters:
STATE_W, 21, state register width (>=2)
IN_W, 3, input width (1..STATE_W); zero-extended into state
OUT_W, 6, observed output width (1..STATE_W)
WINDOW, 8, number of updates per capture window (>=1)
SEED, 0, value loaded into state on accepted start
POLY, 'h5, Galois feedback mask for LFSR mode (STATE_W bits)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset
in  input  IN_W  data folded into state
mode  input  2  update rule: 0 HOLD, 1 XOR, 2 LFSR, 3 ROTX
start  input  1  begin capture window (honoured in IDLE only)
ack  input  1  acknowledge signature (honoured in DONE only)
out  output  OUT_W  state[OUT_W-1:0], direct from register
busy  output  1  high while FSM in RUN
sig_valid  output  1  high while FSM in DONE
signature  output  STATE_W  state captured at window end

Behaviour:
- Reset (reset low, async): state=0, counter=0, FSM=IDLE, signature=0; so out=0, busy=0, sig_valid=0.
- Next-state function, with x = zero-extended in:
  - HOLD: state
  - XOR: state ^ x
  - LFSR: {state[W-2:0],1'b0} ^ (state[W-1] ? POLY : 0) ^ x
  - ROTX: {state[W-2:0],state[W-1]} ^ x
- mode and in are sampled every cycle; a mode change takes effect on the next edge.
- FSM states and transitions:
  - IDLE: state <= next (free-running, legacy-compatible). On start: state <= SEED, counter <= 0, go to RUN.
  - RUN: state <= next, counter++. On the WINDOW-th update: signature <= that updated value, go to DONE. busy is high for exactly WINDOW cycles.
  - DONE: state frozen. On ack: go to IDLE. signature is held until the next capture and is not cleared by ack.
- start outside IDLE is ignored. ack outside DONE is ignored.
- start and ack together in DONE: go to IDLE only; no new window starts.
- Counter width: $clog2(WINDOW+1). It does not wrap within a window.
- Elaboration error if IN_W>STATE_W, OUT_W>STATE_W, WINDOW<1 or STATE_W<2.
- Reset mid-RUN or mid-DONE aborts immediately to reset values. The next start runs a full window.

Optional Feature:
- Macro BENCH_SEQ_PARITY_EN.
- Defined: extra output port out_parity (1 bit) = XOR-reduce of state. The registered sig_parity, reset to 0, is captured alongside signature.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package bench_seq_pkg: mode enum (MODE_HOLD/XOR/LFSR/ROTX), FSM state enum (ST_IDLE/RUN/DONE), default POLY constant.
- One sub-module, bench_seq_next: purely combinational next-state function (state, in, mode -> next), reusable by future benchmarks.

Test Plan:
1. Reset and free-run: reset low with in=3'b101, mode=1 -> out=0, flags 0. Release reset -> out=6'b000101 after edge 1, 0 after edge 2.
2. XOR window: defaults, SEED=0, mode=1, in=3'b011 constant, pulse start -> busy high exactly 8 cycles, then sig_valid=1, signature=21'h0.
3. LFSR shift: SEED=1, mode=2, in=0, WINDOW=8 -> signature=21'h000100. Feedback case with WINDOW=1, SEED=21'h100000 -> signature=21'h000005.
4. ROTX wrap: SEED=21'h100000, mode=3, in=0, WINDOW=1 -> signature=21'h000001.
5. Handshake: start during RUN -> no restart, window length unchanged. sig_valid holds until ack. Assert ack+start together -> IDLE, busy stays 0, signature retained.
6. Reset mid-RUN after 3 updates -> all outputs 0, IDLE. Next start -> full 8-cycle busy.
